down_count_arb: RTL and testbench

DOWN_COUNT_ARB -- requirements
Module: down_count_arb

---
 rtl/down_count_arb_pkg.sv | 13 +
 rtl/down_count_core.sv | 41 ++++
 rtl/down_count_arb.sv | 135 +++++++++++++
 tb/tb_down_count_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_count_arb_pkg.sv
// Shared types and constants for the two-requester down-count arbiter.
package down_count_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int NREQ      = 2;
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/down_count_core.sv
// Loadable WIDTH-bit down counter with enable and zero flag; saturates at zero.
module down_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/down_count_arb.sv
// Round-robin arbiter granting a shared down counter to one of two requesters.
// Optional feature: define DOWN_COUNT_ARB_PAUSE_EN to add a pause input that stalls COUNT.
module down_count_arb
  import down_count_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] load0,
  input  logic [WIDTH-1:0] load1,
`ifdef DOWN_COUNT_ARB_PAUSE_EN
  input  logic             pause,
`endif
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic [1:0]       done
);

  state_e           state_d, state_q;
  logic             owner_d, owner_q;
  logic             rr_d, rr_q;
  logic [1:0]       gnt_d, gnt_q;
  logic [1:0]       done_d, done_q;
  logic             busy_d, busy_q;
  logic             winner_s;
  logic             pause_s;
  logic             load_s;
  logic             en_s;
  logic             zero_s;
  logic [WIDTH-1:0] load_val_s;

`ifdef DOWN_COUNT_ARB_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // A lone requester wins outright; on contention the pointer decides.
  always_comb begin
    winner_s = rr_q;
    case (req)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      default: winner_s = rr_q;
    endcase
  end

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    load_s  = 1'b0;
    en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d = ST_COUNT;
          owner_d = winner_s;
          gnt_d   = winner_s ? 2'b10 : 2'b01;
          load_s  = 1'b1;
        end else begin
          gnt_d = 2'b00;
        end
      end
      ST_COUNT: begin
        // Abort takes priority over pause and terminal count.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          rr_d    = ~owner_q;
        end else if (pause_s) begin
          state_d = ST_COUNT;
        end else if (zero_s) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else begin
          en_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        rr_d    = ~owner_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
    load_val_s = owner_d ? load1 : load0;
    busy_d     = (state_d != ST_IDLE);
  end

  // State, ownership, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  down_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .en      (en_s),
    .load_val(load_val_s),
    .cnt     (cnt),
    .zero    (zero_s)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_count_arb.sv
// Directed self-checking bench for down_count_arb (pause scenario needs DOWN_COUNT_ARB_PAUSE_EN).
module tb_down_count_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] load0;
  logic [3:0] load1;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] cnt;
  logic [1:0] done;
`ifdef DOWN_COUNT_ARB_PAUSE_EN
  logic       pause;
`endif

  int errors = 0;
  int checks = 0;

  logic [8:0] obs;
  assign obs = {gnt, done, busy, cnt};

  down_count_arb #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .load0(load0),
    .load1(load1),
`ifdef DOWN_COUNT_ARB_PAUSE_EN
    .pause(pause),
`endif
    .gnt  (gnt),
    .busy (busy),
    .cnt  (cnt),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // obs layout: {gnt[1:0], done[1:0], busy, cnt[3:0]}
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL reset_hold gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL reset_release gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_cnt;
    req = 2'b01; load0 = 4'd11;
    @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_1011) begin
      $display("FAIL single_grant gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_1011);
      errors++;
    end
    exp_cnt = 4'd11;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      exp_cnt = exp_cnt - 4'd1;
      checks++;
      if (obs !== {2'b01, 2'b00, 1'b1, exp_cnt}) begin
        $display("FAIL single_count step=%0d gnt/done/busy/cnt=%b expected %b", i, obs, {2'b01, 2'b00, 1'b1, exp_cnt});
        errors++;
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b01_01_1_0000) begin
      $display("FAIL single_done gnt/done/busy/cnt=%b expected %b", obs, 9'b01_01_1_0000);
      errors++;
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL single_idle gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11; load0 = 4'd2; load1 = 4'd3;
    @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_0010) begin
      $display("FAIL rr_first_grant gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_0010);
      errors++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 9'b01_01_1_0000) begin
      $display("FAIL rr_first_done gnt/done/busy/cnt=%b expected %b", obs, 9'b01_01_1_0000);
      errors++;
    end
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL rr_gap_idle gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b10_00_1_0011) begin
      $display("FAIL rr_second_grant gnt/done/busy/cnt=%b expected %b", obs, 9'b10_00_1_0011);
      errors++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== 9'b10_10_1_0000) begin
      $display("FAIL rr_second_done gnt/done/busy/cnt=%b expected %b", obs, 9'b10_10_1_0000);
      errors++;
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_zero_load();
    req = 2'b10; load1 = 4'd0; load0 = 4'd9;
    @(negedge clk);
    checks++;
    if (obs !== 9'b10_00_1_0000) begin
      $display("FAIL zero_count gnt/done/busy/cnt=%b expected %b", obs, 9'b10_00_1_0000);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b10_10_1_0000) begin
      $display("FAIL zero_done gnt/done/busy/cnt=%b expected %b", obs, 9'b10_10_1_0000);
      errors++;
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL zero_idle gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
  endtask

  task automatic test_abort();
    req = 2'b11; load0 = 4'd9; load1 = 4'd4;
    @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_1001) begin
      $display("FAIL abort_grant gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_1001);
      errors++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_0101) begin
      $display("FAIL abort_at5 gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_0101);
      errors++;
    end
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0101) begin
      $display("FAIL abort_idle gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0101);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b10_00_1_0100) begin
      $display("FAIL abort_next_grant gnt/done/busy/cnt=%b expected %b", obs, 9'b10_00_1_0100);
      errors++;
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0100) begin
      $display("FAIL abort2_idle gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0100);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; load0 = 4'd12;
    @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_0111) begin
      $display("FAIL rstmid_at7 gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_0111);
      errors++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL rstmid_async gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL rstmid_held gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
    req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 9'b00_00_0_0000) begin
      $display("FAIL rstmid_after gnt/done/busy/cnt=%b expected %b", obs, 9'b00_00_0_0000);
      errors++;
    end
  endtask

`ifdef DOWN_COUNT_ARB_PAUSE_EN
  task automatic test_pause();
    int edges;
    req = 2'b01; load0 = 4'd8; pause = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 9'b01_00_1_0110) begin
      $display("FAIL pause_at6 gnt/done/busy/cnt=%b expected %b", obs, 9'b01_00_1_0110);
      errors++;
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b01_00_1_0110) begin
        $display("FAIL pause_hold step=%0d gnt/done/busy/cnt=%b expected %b", i, obs, 9'b01_00_1_0110);
        errors++;
      end
    end
    pause = 1'b0;
    edges = 3;
    for (int i = 0; i < 20; i++) begin
      if (done == 2'b00) begin
        @(negedge clk);
        edges++;
      end
    end
    checks++;
    if (edges !== 10) begin
      $display("FAIL pause_delay edges_to_done=%0d expected %0d", edges, 10);
      errors++;
    end
    req = 2'b00;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    load0 = 4'd0;
    load1 = 4'd0;
`ifdef DOWN_COUNT_ARB_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_zero_load();
    test_abort();
    test_reset_mid();
`ifdef DOWN_COUNT_ARB_PAUSE_EN
    test_pause();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
